// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream source: FSM states and default image geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional macro PIXEL_STREAM_GAP_EN adds the inter-line GAP state.
package pixel_stream_pkg;

   localparam int DEF_IMG_WIDTH  = 512;
   localparam int DEF_IMG_HEIGHT = 512;
   localparam int DEF_ITEM_SIZE  = 8;

   // Output buffer depth; the read-issue credit check is built around two slots.
   localparam int SKID_DEPTH = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STREAM = 3'd1,
`ifdef PIXEL_STREAM_GAP_EN
      ST_GAP    = 3'd2,
`endif
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_skid_buffer.sv
// 2-entry valid/ready FIFO holding a pixel together with its sof/eol tags.
// Latency: an entry written on one edge is presented on pop_* in the following cycle.
// Backpressure: pop side is valid/ready; push side has no ready, the writer reserves room with credits.
module pixel_skid_buffer
   import pixel_stream_pkg::*;
#(
   parameter int WIDTH = DEF_ITEM_SIZE + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   output logic             pop_vld,
   output logic [WIDTH-1:0] pop_dat,
   input  logic             pop_rdy,
   output logic [1:0]       level
);

   logic [WIDTH-1:0] entry_q [SKID_DEPTH];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       level_q;
   logic             pop;

   assign pop_vld = (level_q != 2'd0);
   assign pop     = pop_vld && pop_rdy;
   // Head is forced to zero when empty so stale entries never leak onto the bus.
   assign pop_dat = pop_vld ? entry_q[rd_ptr_q] : '0;
   assign level   = level_q;

   // Storage, pointers and occupancy; head stays put until it is popped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q[0] <= '0;
         entry_q[1] <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         level_q    <= 2'd0;
      end else begin
         if (push_vld) begin
            entry_q[wr_ptr_q] <= push_dat;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         level_q <= level_q + 2'(push_vld) - 2'(pop);
      end
   end

endmodule

// File: rtl/pixel_stream_source.sv
// Reads a frame from memory in raster order and streams it out with sof/eol tags.
// Latency: first pixel valid 2 cycles after start is sampled, then one pixel per cycle while ready is high.
// Backpressure: reads issue only when the 2-entry skid buffer can absorb them; ready low stalls reads at once.
// Optional macro PIXEL_STREAM_GAP_EN: inserts LINE_GAP read-free cycles after every line but the last.
module pixel_stream_source
   import pixel_stream_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int ITEM_SIZE  = DEF_ITEM_SIZE,
   parameter int ADDR_W     = 18,
   parameter int LINE_GAP   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [ITEM_SIZE-1:0] mem_rd_data,
   output logic [ITEM_SIZE-1:0] pixel_out,
   output logic                 pixel_out_valid,
   input  logic                 pixel_out_ready,
   output logic                 sof,
   output logic                 eol,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int COL_W = clog2_min1(IMG_WIDTH);
   localparam int ROW_W = clog2_min1(IMG_HEIGHT);
   localparam int BUF_W = ITEM_SIZE + 2;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   state_t            state_q;
   state_t            state_d;

   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic [ADDR_W-1:0] addr_q;

   // Read return pipeline: memory answers one cycle after the strobe.
   logic              rd_vld_q;
   logic              rd_sof_q;
   logic              rd_eol_q;

   logic              buf_vld;
   logic [BUF_W-1:0]  buf_dat;
   logic [1:0]        buf_level;
   logic              buf_pop;

   logic [2:0]        occ_after;
   logic              slot_free;
   logic              drained;
   logic              is_eol;
   logic              is_last;
   logic              issue;

   assign is_eol  = (col_q == COL_LAST);
   assign is_last = is_eol && (row_q == ROW_LAST);
   assign buf_pop = buf_vld && pixel_out_ready;

   // Slots committed once this cycle ends: buffered pixels plus the read in flight,
   // minus a pixel leaving now. A new read is only allowed if its data will have a home.
   assign occ_after = {1'b0, buf_level} + 3'(rd_vld_q) - 3'(buf_pop);
   assign slot_free = (occ_after < 3'd2);
   assign drained   = (occ_after == 3'd0);

`ifdef PIXEL_STREAM_GAP_EN
   localparam int GAP_W = clog2_min1(LINE_GAP);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LINE_GAP - 1);

   logic [GAP_W-1:0] gap_cnt_q;

   // Counts cycles spent in GAP; the gap starts right after the line's last read, so with
   // ready held high the output shows exactly LINE_GAP idle cycles between lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt_q <= '0;
      end else if (state_q == ST_GAP) begin
         gap_cnt_q <= gap_cnt_q + GAP_W'(1);
      end else begin
         gap_cnt_q <= '0;
      end
   end
`else
   // LINE_GAP only matters when the inter-line gap is built in.
   logic [31:0] line_gap_unused;
   assign line_gap_unused = LINE_GAP;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and read-issue decision; start is only honoured in IDLE.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (slot_free) begin
               issue = 1'b1;
               if (is_last) begin
                  state_d = ST_DRAIN;
               end
`ifdef PIXEL_STREAM_GAP_EN
               else if (is_eol) begin
                  state_d = ST_GAP;
               end
`endif
            end
         end
`ifdef PIXEL_STREAM_GAP_EN
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_STREAM;
            end
         end
`endif
         ST_DRAIN: begin
            // Leave as soon as the final pixel is leaving, so frame_done follows it by one cycle.
            if (drained) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Raster position of the next read; cleared on an accepted start and after the last read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
      end else if ((state_q == ST_IDLE) && start) begin
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
      end else if (issue) begin
         if (is_last) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
         end else if (is_eol) begin
            col_q  <= '0;
            row_q  <= row_q + ROW_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
         end else begin
            col_q  <= col_q + COL_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

   // Carry the frame/line tags alongside the read so they land with the returned pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
         rd_sof_q <= 1'b0;
         rd_eol_q <= 1'b0;
      end else begin
         rd_vld_q <= issue;
         rd_sof_q <= issue && (addr_q == '0);
         rd_eol_q <= issue && is_eol;
      end
   end

   pixel_skid_buffer #(
      .WIDTH (BUF_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .push_vld (rd_vld_q),
      .push_dat ({rd_sof_q, rd_eol_q, mem_rd_data}),
      .pop_vld  (buf_vld),
      .pop_dat  (buf_dat),
      .pop_rdy  (pixel_out_ready),
      .level    (buf_level)
   );

   assign mem_rd_en       = issue;
   assign mem_addr        = addr_q;
   assign pixel_out       = buf_dat[ITEM_SIZE-1:0];
   assign eol             = buf_dat[ITEM_SIZE];
   assign sof             = buf_dat[ITEM_SIZE+1];
   assign pixel_out_valid = buf_vld;
   assign busy            = (state_q != ST_IDLE);
   assign frame_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source on a 4x3 image with a behavioural frame memory.
// Expected streams come from the raster rules: pixel i = mem[i], sof at i==0, eol at i%W==W-1.
// Ready patterns: held high, toggling, random, a 10-cycle stall; also reset abort and busy start.
module tb_pixel_stream_source;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int NPIX = W * H;
   localparam int IW   = 8;
   localparam int AW   = 4;
   localparam int LG   = 4;
`ifdef PIXEL_STREAM_GAP_EN
   localparam int GAP_EXP = LG;
`else
   localparam int GAP_EXP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          pixel_out_ready = 1'b0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [IW-1:0] mem_rd_data = '0;
   logic [IW-1:0] pixel_out;
   logic          pixel_out_valid;
   logic          sof;
   logic          eol;
   logic          busy;
   logic          frame_done;

   logic [IW-1:0] mem [16];

   int checks = 0;
   int errors = 0;

   // Results gathered by run_frame.
   logic [IW+1:0] got_tag[$];
   int            got_cyc[$];
   int            fd_cnt;
   int            fd_cyc;
   int            unstable;
   int            max_out;
   int            stall_max_addr;
   logic          busy0;
   logic          busy_end;
   logic          timed_out;

   wire [AW+IW+5:0] all_out = {mem_rd_en, mem_addr, pixel_out, pixel_out_valid,
                               sof, eol, busy, frame_done};

   pixel_stream_source #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .ITEM_SIZE  (IW),
      .ADDR_W     (AW),
      .LINE_GAP   (LG)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .mem_rd_en       (mem_rd_en),
      .mem_addr        (mem_addr),
      .mem_rd_data     (mem_rd_data),
      .pixel_out       (pixel_out),
      .pixel_out_valid (pixel_out_valid),
      .pixel_out_ready (pixel_out_ready),
      .sof             (sof),
      .eol             (eol),
      .busy            (busy),
      .frame_done      (frame_done)
   );

   always #5 clk = ~clk;

   // Frame memory: data valid one cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   function automatic logic [IW+1:0] exp_tag(input int i);
      return {(i == 0), (i % W == W - 1), mem[i]};
   endfunction

   function automatic int exp_cyc(input int i);
      return 2 + i + (i / W) * GAP_EXP;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 16; i++) mem[i] = IW'($urandom);
   endtask

   // mode 0: ready high, 1: toggling, 2: random, 3: 10-cycle stall while pixel 5 is shown.
   task automatic run_frame(input int mode, input bit extra_start);
      logic [IW+2:0] prev = '0;
      bit            held = 1'b0;
      bit            stalled_once = 1'b0;
      int            stall_left = 0;
      int            issued = 0;
      got_tag.delete();
      got_cyc.delete();
      fd_cnt = 0; fd_cyc = -1; unstable = 0; max_out = 0; stall_max_addr = 0;
      busy0 = 1'b0; timed_out = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      pixel_out_ready = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         start = extra_start && (n == 4 || n == 9);
         case (mode)
            1: pixel_out_ready = (n % 2 == 0);
            2: pixel_out_ready = ($urandom_range(0, 2) != 0);
            3: begin
               pixel_out_ready = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end
            default: pixel_out_ready = 1'b1;
         endcase
         @(negedge clk);
         if (n == 0) busy0 = busy;
         if (mem_rd_en) begin
            issued++;
            if (mode == 3 && !pixel_out_ready && int'(mem_addr) > stall_max_addr)
               stall_max_addr = int'(mem_addr);
         end
         if (held && {pixel_out_valid, sof, eol, pixel_out} !== prev) unstable++;
         held = pixel_out_valid && !pixel_out_ready;
         prev = {pixel_out_valid, sof, eol, pixel_out};
         if (pixel_out_valid && pixel_out_ready) begin
            got_tag.push_back({sof, eol, pixel_out});
            got_cyc.push_back(n);
            if (mode == 3 && got_tag.size() == 5 && !stalled_once) begin
               stall_left = 10;
               stalled_once = 1'b1;
            end
         end
         if (issued - got_tag.size() > max_out) max_out = issued - got_tag.size();
         if (frame_done) begin
            fd_cnt++;
            if (fd_cyc < 0) fd_cyc = n;
         end
         if (fd_cyc >= 0 && n >= fd_cyc + 3) begin
            timed_out = 1'b0;
            break;
         end
      end
      busy_end = busy;
      pixel_out_ready = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL reset_async got %h want 0", all_out);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL reset_outputs got %h want 0", all_out);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({busy, pixel_out_valid, mem_rd_en} !== 3'b000) begin
            errors++; $display("FAIL idle_quiet[%0d] got %b want 000", k, {busy, pixel_out_valid, mem_rd_en});
         end
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 16; i++) mem[i] = IW'(i);
      run_frame(0, 1'b0);
      checks++;
      if (timed_out) begin errors++; $display("FAIL basic_timeout got no frame_done want 1"); end
      checks++;
      if (got_tag.size() != NPIX) begin
         errors++; $display("FAIL basic_count got %0d want %0d", got_tag.size(), NPIX);
      end
      for (int i = 0; i < got_tag.size() && i < NPIX; i++) begin
         checks++;
         if (got_tag[i] !== exp_tag(i)) begin
            errors++; $display("FAIL basic_pix[%0d] got %h want %h", i, got_tag[i], exp_tag(i));
         end
         checks++;
         if (got_cyc[i] !== exp_cyc(i)) begin
            errors++; $display("FAIL basic_cyc[%0d] got %0d want %0d", i, got_cyc[i], exp_cyc(i));
         end
      end
      checks++;
      if (fd_cnt != 1 || fd_cyc != exp_cyc(NPIX - 1) + 1) begin
         errors++; $display("FAIL basic_done got cnt %0d cyc %0d want cnt 1 cyc %0d", fd_cnt, fd_cyc, exp_cyc(NPIX - 1) + 1);
      end
      checks++;
      if (busy0 !== 1'b1 || busy_end !== 1'b0) begin
         errors++; $display("FAIL basic_busy got %b%b want 10", busy0, busy_end);
      end
   endtask

   task automatic test_toggle();
      fill_random();
      run_frame(1, 1'b0);
      checks++;
      if (got_tag.size() != NPIX || timed_out) begin
         errors++; $display("FAIL toggle_count got %0d want %0d", got_tag.size(), NPIX);
      end
      for (int i = 0; i < got_tag.size() && i < NPIX; i++) begin
         checks++;
         if (got_tag[i] !== exp_tag(i)) begin
            errors++; $display("FAIL toggle_pix[%0d] got %h want %h", i, got_tag[i], exp_tag(i));
         end
      end
      checks++;
      if (unstable != 0) begin errors++; $display("FAIL toggle_stable got %0d changes want 0", unstable); end
      checks++;
      if (fd_cnt != 1) begin errors++; $display("FAIL toggle_done got %0d want 1", fd_cnt); end
      checks++;
      if (max_out > 2) begin errors++; $display("FAIL toggle_credit got %0d want <=2", max_out); end
   endtask

   task automatic test_stall();
      fill_random();
      run_frame(3, 1'b0);
      checks++;
      if (got_tag.size() != NPIX || timed_out) begin
         errors++; $display("FAIL stall_count got %0d want %0d", got_tag.size(), NPIX);
      end
      for (int i = 0; i < got_tag.size() && i < NPIX; i++) begin
         checks++;
         if (got_tag[i] !== exp_tag(i)) begin
            errors++; $display("FAIL stall_pix[%0d] got %h want %h", i, got_tag[i], exp_tag(i));
         end
      end
      checks++;
      if (stall_max_addr > 7) begin
         errors++; $display("FAIL stall_reads got addr %0d want <=7", stall_max_addr);
      end
      checks++;
      if (unstable != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", unstable); end
      checks++;
      if (max_out > 2) begin errors++; $display("FAIL stall_credit got %0d want <=2", max_out); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 3; f++) begin
         fill_random();
         run_frame(2, 1'b0);
         checks++;
         if (got_tag.size() != NPIX || timed_out) begin
            errors++; $display("FAIL rand%0d_count got %0d want %0d", f, got_tag.size(), NPIX);
         end
         for (int i = 0; i < got_tag.size() && i < NPIX; i++) begin
            checks++;
            if (got_tag[i] !== exp_tag(i)) begin
               errors++; $display("FAIL rand%0d_pix[%0d] got %h want %h", f, i, got_tag[i], exp_tag(i));
            end
         end
         checks++;
         if (unstable != 0 || fd_cnt != 1 || max_out > 2) begin
            errors++; $display("FAIL rand%0d_flow got unstable %0d done %0d out %0d want 0 1 <=2", f, unstable, fd_cnt, max_out);
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      bit found = 1'b0;
      int fd_seen = 0;
      int vld_seen = 0;
      fill_random();
      @(posedge clk); #1;
      start = 1'b1;
      pixel_out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge clk);
         if (frame_done) fd_seen++;
         if (pixel_out_valid) begin
            if (seen == 6) found = 1'b1;
            else seen++;
         end
      end
      checks++;
      if (!found || pixel_out !== mem[6]) begin
         errors++; $display("FAIL rstmid_reach got found %0d pix %h want 1 %h", found, pixel_out, mem[6]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL rstmid_outputs got %h want 0", all_out); end
      repeat (2) begin
         @(negedge clk);
         if (frame_done) fd_seen++;
      end
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (frame_done) fd_seen++;
         if (pixel_out_valid || busy) vld_seen++;
      end
      checks++;
      if (fd_seen != 0 || vld_seen != 0) begin
         errors++; $display("FAIL rstmid_abort got done %0d active %0d want 0 0", fd_seen, vld_seen);
      end
      run_frame(0, 1'b0);
      checks++;
      if (got_tag.size() != NPIX || fd_cnt != 1) begin
         errors++; $display("FAIL rstmid_restart got %0d pixels %0d done want %0d 1", got_tag.size(), fd_cnt, NPIX);
      end
      for (int i = 0; i < got_tag.size() && i < NPIX; i++) begin
         checks++;
         if (got_tag[i] !== exp_tag(i)) begin
            errors++; $display("FAIL rstmid_pix[%0d] got %h want %h", i, got_tag[i], exp_tag(i));
         end
      end
   endtask

   task automatic test_start_busy();
      int late_busy = 0;
      fill_random();
      run_frame(0, 1'b1);
      checks++;
      if (got_tag.size() != NPIX || timed_out) begin
         errors++; $display("FAIL busystart_count got %0d want %0d", got_tag.size(), NPIX);
      end
      for (int i = 0; i < got_tag.size() && i < NPIX; i++) begin
         checks++;
         if (got_tag[i] !== exp_tag(i) || got_cyc[i] !== exp_cyc(i)) begin
            errors++; $display("FAIL busystart_pix[%0d] got %h@%0d want %h@%0d", i, got_tag[i], got_cyc[i], exp_tag(i), exp_cyc(i));
         end
      end
      repeat (10) begin
         @(negedge clk);
         if (busy || frame_done) late_busy++;
      end
      checks++;
      if (fd_cnt != 1 || late_busy != 0) begin
         errors++; $display("FAIL busystart_done got done %0d late %0d want 1 0", fd_cnt, late_busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_toggle();
      test_stall();
      test_random();
      test_reset_mid();
      test_start_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_stream_source.md
PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 512, lines per frame.
REQ-003 SHALL have parameter ITEM_SIZE, default 8, bits per pixel.
REQ-004 SHALL have parameter ADDR_W, default 18, frame-memory address width; requires 2**ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
REQ-005 SHALL have parameter LINE_GAP, default 4, idle cycles inserted after each line; used only when PIXEL_STREAM_GAP_EN is defined.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 start  input  1  one-cycle pulse, begin a frame.
REQ-009 mem_rd_en  output  1  frame-memory read strobe.
REQ-010 mem_addr  output  ADDR_W  raster read address, row*IMG_WIDTH+col.
REQ-011 mem_rd_data  input  ITEM_SIZE  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 pixel_out  output  ITEM_SIZE  streamed pixel; connects to pixel_loader pixel_in.
REQ-013 pixel_out_valid  output  1  pixel_out holds a pixel.
REQ-014 pixel_out_ready  input  1  sink accepts; tie to 1 for pixel_loader.
REQ-015 sof  output  1  high with the first pixel of the frame (row 0, col 0).
REQ-016 eol  output  1  high with the last pixel of each line.
REQ-017 busy  output  1  high from accepted start until frame_done.
REQ-018 frame_done  output  1  one-cycle pulse after last pixel transfer.

Function
REQ-019 Transfer SHALL occur on a cycle with pixel_out_valid and pixel_out_ready both high; pixel_out, sof, eol SHALL be held stable while valid is high and ready low.
REQ-020 FSM states SHALL be IDLE, STREAM, GAP, DRAIN, DONE.
REQ-021 IDLE->STREAM on start; start SHALL be ignored in any other state.
REQ-022 STREAM SHALL issue reads in raster order, col wrapping IMG_WIDTH-1->0 with row increment, and only while the output skid buffer has a free slot counting in-flight reads.
REQ-023 After issuing col IMG_WIDTH-1 of a row not the last: STREAM->GAP if PIXEL_STREAM_GAP_EN, else remain STREAM.
REQ-024 After issuing the last address (IMG_WIDTH*IMG_HEIGHT-1): STREAM->DRAIN; DRAIN->DONE when buffer empty and no read in flight; DONE asserts frame_done one cycle, then ->IDLE.
REQ-025 With ready held high and no gap, first valid SHALL appear 2 cycles after start is sampled, then one pixel per cycle, no bubbles; frame occupies IMG_WIDTH*IMG_HEIGHT consecutive valid cycles.
REQ-026 Skid buffer SHALL be 2 entries; no pixel lost or duplicated under any ready pattern; buffer full with a read in flight SHALL NOT occur.
REQ-027 Ready deasserted mid-line SHALL stall reads within 1 cycle; resume SHALL continue at the next pixel in order.
REQ-028 eol on the last pixel of the last line SHALL coincide with final transfer; sof and eol both high only when IMG_WIDTH=1.

Reset
REQ-029 On rst: state IDLE, counters 0, buffer empty, all outputs 0 (mem_addr 0, pixel_out 0), within the same cycle, asynchronously.
REQ-030 rst mid-frame SHALL abort the frame without frame_done; next start SHALL restart at address 0.

Configuration
REQ-031 Macro PIXEL_STREAM_GAP_EN defined: GAP state present, exactly LINE_GAP cycles with no reads and pixel_out_valid low after each line's transfers drain, then ->STREAM; undefined: GAP state and LINE_GAP logic absent, lines back-to-back.

Structure
REQ-032 Package pixel_stream_pkg SHALL hold the FSM state enum typedef and default IMG_WIDTH/IMG_HEIGHT/ITEM_SIZE constants.
REQ-033 One sub-module, pixel_skid_buffer (2-entry valid/ready FIFO, ITEM_SIZE+2 wide carrying sof/eol), SHALL be instantiated.

Verification
REQ-034 IMG 4x3, ready=1, memory[i]=i, start -> pixels 0..11 on 12 consecutive cycles beginning 2 cycles after start, sof at 0, eol at 3,7,11, frame_done one cycle after pixel 11.
REQ-035 IMG 4x3, ready toggling 1,0,1,0... -> sequence 0..11 exact, no repeats, outputs stable during ready=0.
REQ-036 ready=0 for 10 cycles at pixel 5 -> at most 2 reads beyond pixel 5 issued; stream resumes 5,6,7...
REQ-037 rst asserted at pixel 6 -> all outputs 0 immediately, no frame_done; new start -> stream restarts at 0 with sof.
REQ-038 PIXEL_STREAM_GAP_EN, LINE_GAP=4, IMG 4x3 -> exactly 4 invalid cycles after pixels 3 and 7, none after 11; total frame 20 cycles.
REQ-039 start pulsed while busy -> ignored, frame continues unchanged, single frame_done.
